lbp_window_gen: RTL and testbench

//  Upstream stage of the LBP core inside CHIP. Converts the raster pixel stream from the input pads
//  (in_valid/in_image, row-major, one pixel per accepted cycle) into 3x3 neighbourhoods.

---
 rtl/lbp_window_gen_pkg.sv | 26 ++
 rtl/lbp_window_gen_if.sv | 29 ++
 rtl/lbp_window_gen_line_buf.sv | 32 +++
 rtl/lbp_window_gen.sv | 137 +++++++++++++
 tb/tb_lbp_window_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_window_gen_pkg.sv
// Shared constants for the LBP window generator: default image geometry,
// 3x3 window slot indices and a counter-width helper.
package lbp_pkg;

    localparam int unsigned DEF_IMG_W = 64;
    localparam int unsigned DEF_IMG_H = 64;
    localparam int unsigned DEF_PIX_W = 8;

    // Window slots, row-major, top-left first; WIN_C is the centre pixel.
    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_T  = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_L  = 3;
    localparam int unsigned WIN_C  = 4;
    localparam int unsigned WIN_R  = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_B  = 7;
    localparam int unsigned WIN_BR = 8;
    localparam int unsigned WIN_N  = 9;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lbp_window_gen_if.sv
// Pixel stream in, 3x3 window stream out. The master drives pixels and
// observes windows; the slave is the window generator itself.
interface lbp_window_gen_if
    import lbp_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned ROW_W = cnt_w(DEF_IMG_H),
    parameter int unsigned COL_W = cnt_w(DEF_IMG_W)
);

    logic                   in_valid;
    logic [PIX_W-1:0]       in_image;
    logic                   win_valid;
    logic [WIN_N*PIX_W-1:0] win_pix;
    logic [ROW_W-1:0]       cen_row;
    logic [COL_W-1:0]       cen_col;
    logic                   frame_done;

    modport master (
        output in_valid, in_image,
        input  win_valid, win_pix, cen_row, cen_col, frame_done
    );

    modport slave (
        input  in_valid, in_image,
        output win_valid, win_pix, cen_row, cen_col, frame_done
    );

endinterface

// File: rtl/lbp_window_gen_line_buf.sv
// Shift-enabled register delay line: dout_o is the value written DEPTH
// enabled cycles earlier.
module lbp_line_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift one place on every enabled cycle; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/lbp_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood converter. Two line delay lines
// supply the two rows above the incoming pixel; a 3x3 register shifts in one
// column per accepted pixel. Border centres are masked from win_valid.
module lbp_window_gen
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input logic             clk,
    input logic             rst_n,
    lbp_window_gen_if.slave bus
);

    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned COL_W = cnt_w(IMG_W);

    logic             accept;
    logic [PIX_W-1:0] lb0_out;
    logic [PIX_W-1:0] lb1_out;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last, row_last;
    logic             win_ok;

    logic [PIX_W-1:0] win_q [WIN_N];
    logic             win_valid_q;
    logic [ROW_W-1:0] cen_row_q;
    logic [COL_W-1:0] cen_col_q;
    logic             frame_done_q;

    assign accept   = bus.in_valid;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    // Centre (row-1, col-1) is interior only once two full rows and columns are in.
    assign win_ok   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // LB0 yields the pixel one row above, LB1 the pixel two rows above.
    lbp_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .din_i  (bus.in_image),
        .dout_o (lb0_out)
    );

    lbp_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .din_i  (lb0_out),
        .dout_o (lb1_out)
    );

    // Raster position of the pixel about to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window register: shift left one column, new column {LB1, LB0, in} on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN_N; k++) begin
                win_q[k] <= '0;
            end
        end else if (accept) begin
            win_q[WIN_TL] <= win_q[WIN_T];
            win_q[WIN_T]  <= win_q[WIN_TR];
            win_q[WIN_TR] <= lb1_out;
            win_q[WIN_L]  <= win_q[WIN_C];
            win_q[WIN_C]  <= win_q[WIN_R];
            win_q[WIN_R]  <= lb0_out;
            win_q[WIN_BL] <= win_q[WIN_B];
            win_q[WIN_B]  <= win_q[WIN_BR];
            win_q[WIN_BR] <= bus.in_image;
        end
    end

    // Registered window qualifiers; centre coordinates hold between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            cen_row_q    <= '0;
            cen_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= accept && win_ok;
            frame_done_q <= accept && row_last && col_last;
            if (accept && win_ok) begin
                cen_row_q <= row_q - ROW_W'(1);
                cen_col_q <= col_q - COL_W'(1);
            end
        end
    end

    // Pack window slots onto the output bus.
    always_comb begin
        bus.win_pix = '0;
        for (int k = 0; k < WIN_N; k++) begin
            bus.win_pix[PIX_W*k +: PIX_W] = win_q[k];
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.cen_row    = cen_row_q;
    assign bus.cen_col    = cen_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lbp_window_gen.sv
// Bench for lbp_window_gen: streams whole frames from an image array and
// checks every cycle against windows cut directly out of that array.
module tb_lbp_window_gen;

    localparam int W = 64;
    localparam int H = 64;

    logic clk;
    logic rst_n;

    lbp_window_gen_if #(.PIX_W(8), .ROW_W(6), .COL_W(6)) bus ();

    lbp_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [7:0]  img [H][W];
    // Per-frame observations.
    int          n_win;
    int          n_done;
    int          first_win_idx;
    logic [71:0] first_pix;
    logic [11:0] cen_q [$];
    // Model state carried across cycles.
    logic [5:0]  exp_cen_r, exp_cen_c;
    logic [71:0] last_exp_pix;
    logic        last_acc_valid;
    int          cyc;

    task automatic fill_img(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       img[r][c] = 8'((r * 64 + c) & 255);
                    1:       img[r][c] = ~8'((r * 64 + c) & 255);
                    2:       img[r][c] = 8'hAA;
                    default: img[r][c] = 8'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_image = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cen_r = 6'd0;
        exp_cen_c = 6'd0;
        last_acc_valid = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [7:0] p);
        bus.in_valid = v;
        bus.in_image = p;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle cycles: nothing may be emitted, outputs hold.
    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'($urandom_range(255)));
            checks++;
            if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle: win_valid=%b frame_done=%b, required 0 0",
                         bus.win_valid, bus.frame_done);
            end
            checks++;
            if (bus.cen_row !== exp_cen_r || bus.cen_col !== exp_cen_c) begin
                failures++;
                $display("FAIL gap_cen_hold: got (%0d,%0d) required (%0d,%0d)",
                         bus.cen_row, bus.cen_col, exp_cen_r, exp_cen_c);
            end
            if (last_acc_valid) begin
                checks++;
                if (bus.win_pix !== last_exp_pix) begin
                    failures++;
                    $display("FAIL gap_pix_hold: got %h required %h", bus.win_pix, last_exp_pix);
                end
            end
        end
    endtask

    // Stream img as one frame. gap_mode 0: none, 1: every 3rd cycle idle plus 10 idle
    // cycles after each row, 2: random idles.
    task automatic stream_frame(input int gap_mode);
        logic        exp_v;
        logic [71:0] ep;
        n_win = 0;
        n_done = 0;
        first_win_idx = -1;
        first_pix = '0;
        cen_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap_mode == 1) begin
                    if (cyc % 3 == 2) gap_cycles(1);
                end else if (gap_mode == 2) begin
                    while ($urandom_range(3) == 0) gap_cycles(1);
                end
                drive(1'b1, img[r][c]);
                exp_v = (r >= 2) && (c >= 2);
                ep = '0;
                if (exp_v) begin
                    for (int k = 0; k < 9; k++) begin
                        ep[8*k +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
                    end
                end
                checks++;
                if (bus.win_valid !== exp_v) begin
                    failures++;
                    $display("FAIL win_valid @pix(%0d,%0d): got %b required %b",
                             r, c, bus.win_valid, exp_v);
                end
                checks++;
                if (bus.frame_done !== (r == H - 1 && c == W - 1)) begin
                    failures++;
                    $display("FAIL frame_done @pix(%0d,%0d): got %b", r, c, bus.frame_done);
                end
                if (exp_v) begin
                    exp_cen_r = 6'(r - 1);
                    exp_cen_c = 6'(c - 1);
                    last_exp_pix = ep;
                    checks++;
                    if (bus.win_pix !== ep) begin
                        failures++;
                        $display("FAIL win_pix @pix(%0d,%0d): got %h required %h",
                                 r, c, bus.win_pix, ep);
                    end
                end
                checks++;
                if (bus.cen_row !== exp_cen_r || bus.cen_col !== exp_cen_c) begin
                    failures++;
                    $display("FAIL cen @pix(%0d,%0d): got (%0d,%0d) required (%0d,%0d)",
                             r, c, bus.cen_row, bus.cen_col, exp_cen_r, exp_cen_c);
                end
                last_acc_valid = exp_v;
                if (bus.win_valid === 1'b1) begin
                    if (n_win == 0) begin
                        first_win_idx = r * W + c;
                        first_pix = bus.win_pix;
                    end
                    n_win++;
                    cen_q.push_back({bus.cen_row, bus.cen_col});
                end
                if (bus.frame_done === 1'b1) begin
                    n_done++;
                    checks++;
                    if (bus.win_valid !== 1'b1 || bus.cen_row !== 6'd62 ||
                        bus.cen_col !== 6'd62) begin
                        failures++;
                        $display("FAIL done_window: valid=%b cen (%0d,%0d) required 1 (62,62)",
                                 bus.win_valid, bus.cen_row, bus.cen_col);
                    end
                end
                if (gap_mode == 1 && c == W - 1) gap_cycles(10);
            end
        end
    endtask

    task automatic check_count(input int got, input int req, input string name);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_image = 8'h00;
        #12;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_pix !== 72'h0 ||
            bus.cen_row !== 6'd0 || bus.cen_col !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b done=%b pix=%h cen=(%0d,%0d) required all 0",
                     bus.win_valid, bus.frame_done, bus.win_pix, bus.cen_row, bus.cen_col);
        end
        do_reset();
    endtask

    task automatic test_ramp();
        do_reset();
        fill_img(0);
        stream_frame(0);
        check_count(n_win, 3844, "ramp_window_count");
        check_count(first_win_idx, 130, "ramp_first_window_index");
        check_count(n_done, 1, "ramp_done_count");
        checks++;
        if (first_pix[7:0] !== 8'd0 || first_pix[39:32] !== 8'd65 ||
            first_pix[71:64] !== 8'd130) begin
            failures++;
            $display("FAIL ramp_first_slots: slot0=%0d slot4=%0d slot8=%0d required 0 65 130",
                     first_pix[7:0], first_pix[39:32], first_pix[71:64]);
        end
        checks++;
        if (cen_q.size() == 0 || cen_q[0] !== {6'd1, 6'd1}) begin
            failures++;
            $display("FAIL ramp_first_centre: got %h required %h",
                     (cen_q.size() > 0) ? cen_q[0] : 12'hFFF, {6'd1, 6'd1});
        end
    endtask

    task automatic test_gaps();
        do_reset();
        fill_img(0);
        stream_frame(1);
        check_count(n_win, 3844, "gaps_window_count");
        check_count(first_win_idx, 130, "gaps_first_window_index");
    endtask

    task automatic test_row_boundary();
        int idx;
        int border;
        do_reset();
        fill_img(0);
        stream_frame(0);
        idx = -1;
        border = 0;
        foreach (cen_q[i]) begin
            if (cen_q[i] == {6'd1, 6'd62}) idx = i;
            if (cen_q[i][11:6] == 6'd0 || cen_q[i][11:6] == 6'd63 ||
                cen_q[i][5:0] == 6'd0 || cen_q[i][5:0] == 6'd63) border++;
        end
        checks++;
        if (idx < 0 || idx + 1 >= cen_q.size() || cen_q[idx+1] !== {6'd2, 6'd1}) begin
            failures++;
            $display("FAIL row_boundary_consecutive: index of (1,62)=%0d, next centre %h",
                     idx, (idx >= 0 && idx + 1 < cen_q.size()) ? cen_q[idx+1] : 12'hFFF);
        end
        check_count(border, 0, "row_boundary_border_centres");
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_img(0);
        stream_frame(0);
        check_count(n_done, 1, "b2b_done_frame1");
        fill_img(1);
        stream_frame(0);
        check_count(n_done, 1, "b2b_done_frame2");
        check_count(n_win, 3844, "b2b_window_count2");
        checks++;
        if (first_pix[7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_first_slot0: got %h required ff", first_pix[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 1000; i++) drive(1'b1, 8'($urandom_range(255)));
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_pix !== 72'h0 ||
                bus.cen_row !== 6'd0 || bus.cen_col !== 6'd0) begin
                failures++;
                $display("FAIL reset_mid_outputs[%0d]: valid=%b done=%b pix=%h cen=(%0d,%0d)",
                         i, bus.win_valid, bus.frame_done, bus.win_pix, bus.cen_row,
                         bus.cen_col);
            end
            drive(1'b1, 8'h5A);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        exp_cen_r = 6'd0;
        exp_cen_c = 6'd0;
        last_acc_valid = 1'b0;
        fill_img(0);
        stream_frame(0);
        check_count(n_win, 3844, "reset_mid_window_count");
        check_count(first_win_idx, 130, "reset_mid_first_window_index");
    endtask

    task automatic test_const();
        int rmin, rmax, cmin, cmax;
        do_reset();
        fill_img(2);
        stream_frame(0);
        rmin = 99; rmax = -1; cmin = 99; cmax = -1;
        foreach (cen_q[i]) begin
            if (int'(cen_q[i][11:6]) < rmin) rmin = int'(cen_q[i][11:6]);
            if (int'(cen_q[i][11:6]) > rmax) rmax = int'(cen_q[i][11:6]);
            if (int'(cen_q[i][5:0]) < cmin) cmin = int'(cen_q[i][5:0]);
            if (int'(cen_q[i][5:0]) > cmax) cmax = int'(cen_q[i][5:0]);
        end
        checks++;
        if (rmin != 1 || rmax != 62 || cmin != 1 || cmax != 62) begin
            failures++;
            $display("FAIL const_sweep: rows %0d..%0d cols %0d..%0d required 1..62 1..62",
                     rmin, rmax, cmin, cmax);
        end
        checks++;
        if (first_pix !== {9{8'hAA}}) begin
            failures++;
            $display("FAIL const_first_pix: got %h required all aa", first_pix);
        end
    endtask

    task automatic test_random();
        do_reset();
        fill_img(3);
        stream_frame(2);
        check_count(n_win, 3844, "random_window_count");
        check_count(n_done, 1, "random_done_count");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_image = 8'h00;
        exp_cen_r = 6'd0;
        exp_cen_c = 6'd0;
        last_exp_pix = '0;
        last_acc_valid = 1'b0;
        test_reset();
        test_ramp();
        test_gaps();
        test_row_boundary();
        test_back_to_back();
        test_reset_mid();
        test_const();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
